// File: rtl/sigma_delta_sinc3.sv
// sigma_delta_sinc3: one sigma-delta channel front end.
// Generates the modulator clock mclk, captures the 1-bit stream mdata on
// each mclk rising edge and decimates it with a 3rd-order CIC (sinc3)
// filter by 2^LOG2_DECIM.
// Optional build macro SINC3_SIGNED_OUT_EN: when defined, d is two's
// complement centred on density 0.5; when undefined, d is unsigned.
// Output handshake: dv is a valid-only strobe, high for exactly one c cycle
// per decimated sample; there is no ready, and d is stable until the next dv.
module sigma_delta_sinc3 #(
    parameter int  MCLK_DIV   = 10,
    parameter int  LOG2_DECIM = 6,
    localparam int ACC_W      = 3 * LOG2_DECIM + 1
) (
    input  logic             c,
    input  logic             rst,
    input  logic             en,
    output logic             mclk,
    input  logic             mdata,
    output logic [ACC_W-1:0] d,
    output logic             dv
);

    localparam int               CNT_W       = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(MCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF    = CNT_W'(MCLK_DIV / 2);
    localparam logic [1:0]       SETTLE_DONE = 2'd2;

`ifdef SINC3_SIGNED_OUT_EN
    // Density 0.5 maps to code 0.
    localparam logic [ACC_W-1:0] D_OFFSET = {1'b0, 1'b1, {(3 * LOG2_DECIM - 1){1'b0}}};
`else
    localparam logic [ACC_W-1:0] D_OFFSET = '0;
`endif
    // Reset value of d is the code for density 0.
    localparam logic [ACC_W-1:0] D_RESET = '0 - D_OFFSET;

    logic                  run;
    logic [CNT_W-1:0]      div_cnt;
    logic [CNT_W-1:0]      div_nxt;
    logic                  mclk_nxt;
    logic                  tick;
    logic                  bit_q;
    logic                  tick_q;
    logic                  wrap_q;
    logic [LOG2_DECIM-1:0] samp_cnt;
    logic [ACC_W-1:0]      i1, i2, i3;
    logic                  go1, go2, go3;
    logic [ACC_W-1:0]      x_z1, c1, c1_z1, c2, c2_z1, c3;
    logic [1:0]            settle_cnt;

    assign run = rst & en;

    // Next divider phase; a sample tick is the cycle mclk is driven 0->1.
    always_comb begin
        div_nxt  = (div_cnt == CNT_LAST) ? '0 : div_cnt + 1'b1;
        mclk_nxt = (div_nxt < CNT_HALF);
        tick     = mclk_nxt & ~mclk;
    end

    assign c3 = c2 - c2_z1;

    // mclk divider; parked at the start of the low half so the first rise
    // comes half a period after the channel is enabled.
    always_ff @(posedge c) begin
        if (!run) begin
            div_cnt <= CNT_HALF;
            mclk    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            mclk    <= mclk_nxt;
        end
    end

    // Capture mdata on each sample tick and flag the frame-closing tick.
    always_ff @(posedge c) begin
        if (!run) begin
            bit_q    <= 1'b0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            samp_cnt <= '0;
        end else begin
            tick_q <= tick;
            wrap_q <= tick & (samp_cnt == '1);
            if (tick) begin
                bit_q    <= mdata;
                samp_cnt <= samp_cnt + 1'b1;
            end
        end
    end

    // Three cascaded integrators, modular ACC_W arithmetic, one step per tick.
    always_ff @(posedge c) begin
        if (!run) begin
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
            go1 <= 1'b0;
        end else begin
            go1 <= wrap_q;
            if (tick_q) begin
                i1 <= i1 + {{(ACC_W - 1){1'b0}}, bit_q};
                i2 <= i2 + i1;
                i3 <= i3 + i2;
            end
        end
    end

    // Comb 1: latch the frame's i3 and difference it against the previous frame.
    always_ff @(posedge c) begin
        if (!run) begin
            x_z1 <= '0;
            c1   <= '0;
            go2  <= 1'b0;
        end else begin
            go2 <= go1;
            if (go1) begin
                c1   <= i3 - x_z1;
                x_z1 <= i3;
            end
        end
    end

    // Comb 2.
    always_ff @(posedge c) begin
        if (!run) begin
            c1_z1 <= '0;
            c2    <= '0;
            go3   <= 1'b0;
        end else begin
            go3 <= go2;
            if (go2) begin
                c2    <= c1 - c1_z1;
                c1_z1 <= c1;
            end
        end
    end

    // Comb 3 and output; the first two results after a restart are dropped
    // while the comb history fills. d keeps its value while en is low.
    always_ff @(posedge c) begin
        if (!rst) begin
            d          <= D_RESET;
            dv         <= 1'b0;
            c2_z1      <= '0;
            settle_cnt <= '0;
        end else if (!en) begin
            dv         <= 1'b0;
            c2_z1      <= '0;
            settle_cnt <= '0;
        end else begin
            dv <= 1'b0;
            if (go3) begin
                c2_z1 <= c2;
                if (settle_cnt == SETTLE_DONE) begin
                    d  <= c3 - D_OFFSET;
                    dv <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sigma_delta_sinc3.md
Name: sigma_delta_sinc3

Overview:
Front end for one sigma-delta modulator channel (current/voltage sense) inside meganode. It generates the modulator clock mclk and captures the 1-bit stream mdata. A 3rd-order CIC (sinc3) filter decimates the stream by 2^LOG2_DECIM and emits one unsigned sample per decimation period with a single-cycle valid. meganode instantiates it once per mdata/mclk bit; its output feeds the motor-control current loop.

Parameters:
MCLK_DIV, 10, c cycles per mclk period; even, >=4; mclk high for MCLK_DIV/2 cycles, low for MCLK_DIV/2.
LOG2_DECIM, 6, decimation ratio DECIM = 2^LOG2_DECIM, legal range 2..8.
ACC_W, 3*LOG2_DECIM+1, derived (localparam); integrator, comb and output width.

Ports:
c  input  1  system clock (100 MHz in meganode)
rst  input  1  synchronous reset, active-low
en  input  1  1 = run; 0 = hold mclk low and clear all filter state
mclk  output  1  modulator clock
mdata  input  1  modulator bitstream; modulator updates it after mclk falls
d  output  ACC_W  decimated sample, 0..DECIM^3
dv  output  1  one-cycle strobe, d valid

Behaviour:
- Reset (rst=0 at posedge c): mclk=0, d=0, dv=0. Divider, sample counter, all integrators, all comb delay registers and the settle counter are cleared. Reset mid-decimation discards the partial frame; no dv is produced from it.
- en=0 has the same effect as reset on all state, except that d keeps its last value. While en=0, mclk stays 0. On en 0->1, mclk rises MCLK_DIV/2 cycles later.
- mclk divider: the counter counts 0..MCLK_DIV-1. mclk=1 while count < MCLK_DIV/2, otherwise 0.
- Capture: on the c cycle in which mclk is driven 0->1, mdata is registered as bit b (0 or 1). This capture is the "sample tick". mdata is not synchronised internally; the modulator is clocked by mclk, so mdata is stable at the mclk rising edge.
- Integrators, updated only on sample ticks: i1 += b; i2 += i1; i3 += i2. Each is ACC_W bits, and modular wrap is intended.
- Sample counter, 0..DECIM-1: increments on each sample tick. On the tick where it wraps DECIM-1 -> 0, i3 is latched into the comb input on the following c cycle.
- Comb stage, one pipeline stage per comb, each modular ACC_W subtract: c1 = x - x_z1; c2 = c1 - c1_z1; c3 = c2 - c2_z1.
- Latency: d <= c3 and dv=1 exactly 4 c cycles after the wrapping sample tick. dv is high for exactly one cycle.
- Settling: the first 2 comb outputs after reset or en rising are computed but suppressed (dv stays 0, d unchanged). The 3rd and all later outputs assert dv.
- Throughput: one dv every DECIM*MCLK_DIV c cycles (640 at defaults).
- Arithmetic: constant input density p gives d = p*DECIM^3 exactly once settled. All-ones gives d = 2^(3*LOG2_DECIM), which fits in ACC_W.

Optional Feature:
SINC3_SIGNED_OUT_EN
- Defined: d is two's complement, d = c3 - 2^(3*LOG2_DECIM-1), in the range -2^(3*LOG2_DECIM-1)..+2^(3*LOG2_DECIM-1). Width and latency are unchanged. d resets to -2^(3*LOG2_DECIM-1), i.e. the code for density 0.
- Undefined: unsigned output as above; reset value 0.

Test Plan:
1. Defaults, rst low 5 cycles then high, en=1 -> mclk period 10 cycles, 5 high / 5 low. First dv at the 3rd decimation frame; dv spacing 640 cycles thereafter.
2. mdata constant 0 -> every dv carries d=0. mdata constant 1 -> every dv carries d=0x40000 (262144).
3. mdata alternating 1,0 per mclk -> d=0x20000. Repeating 1,0,0,0 -> d=0x10000. Each value holds exactly on every dv after settling.
4. Step from all-0 to all-1 mid-frame -> d is monotonic non-decreasing across 3 frames, then 0x40000 on every later dv.
5. en dropped mid-frame for 50 cycles, then raised -> mclk low throughout; no dv for the next 2 frames; 3rd frame d matches the input density. Same check with rst pulsed instead of en.
6. With SINC3_SIGNED_OUT_EN, repeat scenarios 2 and 3 -> d=-0x20000, +0x20000, 0 and -0x10000 respectively; d=-0x20000 immediately after reset.
